// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS-232 receiver.
package rs232_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rs232_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/rs232_bit_timer.sv
// Down-counting bit timer: loads on strobe, pulses o_expire when the count
// reaches 1 and reloads itself from i_load_val in that same cycle.
module rs232_bit_timer #(
    parameter int unsigned TW = 5
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_load,
    output logic          o_expire
);

    logic [TW-1:0] r_count;

    assign o_expire = (r_count == TW'(1));

    // Count down; reload on explicit load or on expiry, park at zero after reset
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
        end else if (i_load || o_expire) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/rs232_rx.sv
// RS-232 8N1 receiver with a single-byte holding register, sticky overrun
// flag and a one-cycle framing-error pulse.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int unsigned CLK_HZ = 20_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] Data_out,
    output logic                 Valid_out,
    input  logic                 Ack_in,
    output logic                 Overrun,
    output logic                 Framing_err
);

    localparam int unsigned BIT  = CLK_HZ / BAUD;
    localparam int unsigned HALF = BIT / 2;
    localparam int unsigned TW   = $clog2(BIT + 1);
    localparam int unsigned IW   = $clog2(DATA_BITS);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    rs232_state_e         r_state;
    rs232_state_e         w_next;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ovr;
    logic                 r_ferr;

    logic                 w_rxd_s;
    logic                 w_fall;
    logic                 w_expire;
    logic                 w_load;
    logic [TW-1:0]        w_load_val;
    logic                 w_sample;
    logic                 w_done;
    logic                 w_ferr;

    assign w_rxd_s    = r_sync2;
    assign w_fall     = r_prev & ~w_rxd_s;
    assign w_load_val = (r_state == IDLE) ? TW'(HALF) : TW'(BIT);

    assign Data_out    = r_data;
    assign Valid_out   = r_valid;
    assign Overrun     = r_ovr;
    assign Framing_err = r_ferr;

    rs232_bit_timer #(
        .TW(TW)
    ) u_timer (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_load_val (w_load_val),
        .i_load     (w_load),
        .o_expire   (w_expire)
    );

    // Two-flop synchronizer plus previous-sample register for falling-edge detect
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // FSM state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-cycle strobes
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_sample = 1'b0;
        w_done   = 1'b0;
        w_ferr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_next = START;
                    w_load = 1'b1;
                end
            end
            START: begin
                if (w_expire) begin
                    w_next = w_rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_sample = 1'b1;
                    if (r_idx == IW'(DATA_BITS - 1)) begin
                        w_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_expire) begin
                    w_next = IDLE;
                    if (w_rxd_s) begin
                        w_done = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Bit index and LSB-first shift register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state != DATA) begin
                r_idx <= '0;
            end else if (w_sample) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_sample) begin
                r_shift[r_idx] <= w_rxd_s;
            end
        end
    end

    // Holding register handshake, sticky overrun and framing-error pulse
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            if (w_done) begin
                if (!r_valid || Ack_in) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                    r_ovr   <= 1'b0;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (Ack_in && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs232_rx.sv
// Self-checking bench for rs232_rx: frame-level event model plus directed pins.
module tb_rs232_rx;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int BITC  = 16;
    localparam int HALFC = 8;
    // Completion posedge offset from the posedge after which RXD was driven low:
    // 2 synchronizer cycles + HALF + 9*BIT + 1 output register cycle.
    localparam int LAT = 2 + HALFC + 9 * BITC + 1;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       RXD;
    logic       Ack_in;
    logic [7:0] Data_out;
    logic       Valid_out;
    logic       Overrun;
    logic       Framing_err;

    always #5 Clk = ~Clk;

    rs232_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .RXD         (RXD),
        .Data_out    (Data_out),
        .Valid_out   (Valid_out),
        .Ack_in      (Ack_in),
        .Overrun     (Overrun),
        .Framing_err (Framing_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        bit         good;
        logic [7:0] b;
    } ev_t;
    ev_t evq[$];

    logic [7:0] m_data  = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;
    bit         m_ferr  = 1'b0;
    ev_t        cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: completion events land at fixed offsets from the driven start edge
    always @(posedge Clk) begin
        cyc = cyc + 1;
        m_ferr = 1'b0;
        if (Rst) begin
            evq.delete();
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            bit have;
            have = 1'b0;
            if (evq.size() > 0) begin
                if (evq[0].at == cyc) begin
                    cur  = evq.pop_front();
                    have = 1'b1;
                end
            end
            if (have && !cur.good) begin
                m_ferr = 1'b1;
            end
            if (have && cur.good) begin
                if (!m_valid || Ack_in) begin
                    m_data  = cur.b;
                    m_valid = 1'b1;
                    m_ovr   = 1'b0;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (Ack_in && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
        end
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge Clk) begin
        if (Rst) begin
            chk("rst_data",  {24'h0, Data_out}, 32'h0);
            chk("rst_valid", {31'h0, Valid_out}, 32'h0);
            chk("rst_ovr",   {31'h0, Overrun}, 32'h0);
            chk("rst_ferr",  {31'h0, Framing_err}, 32'h0);
        end else begin
            chk("data",  {24'h0, Data_out}, {24'h0, m_data});
            chk("valid", {31'h0, Valid_out}, {31'h0, m_valid});
            chk("ovr",   {31'h0, Overrun}, {31'h0, m_ovr});
            chk("ferr",  {31'h0, Framing_err}, {31'h0, m_ferr});
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive one 8N1 frame; Ack_in is high at posedge k+ack_off (0 = never).
    // pin=1 adds literal timing checks and assumes Valid_out is 0 beforehand.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int ack_off, input bit pin);
        logic [9:0] w;
        ev_t        e;
        w    = {stop, b, 1'b0};
        e.at = cyc + LAT;
        e.good = stop;
        e.b  = b;
        evq.push_back(e);
        for (int j = 0; j < 10 * BITC; j++) begin
            RXD    = w[j / BITC];
            Ack_in = (j + 1 == ack_off);
            if (pin) begin
                if (j == LAT - 1) begin
                    chk("pin_valid_before", {31'h0, Valid_out}, 32'h0);
                    chk("pin_ferr_before",  {31'h0, Framing_err}, 32'h0);
                end
                if (j == LAT) begin
                    chk("pin_valid_at", {31'h0, Valid_out}, {31'h0, stop});
                    chk("pin_ferr_at",  {31'h0, Framing_err}, {31'h0, ~stop});
                    if (stop) chk("pin_data_at", {24'h0, Data_out}, {24'h0, b});
                end
                if (j == LAT + 1) begin
                    chk("pin_ferr_after", {31'h0, Framing_err}, 32'h0);
                end
            end
            tick();
        end
        Ack_in = 1'b0;
        RXD    = 1'b1;
    endtask

    task automatic idle(input int n, input int ack_off);
        RXD = 1'b1;
        for (int j = 0; j < n; j++) begin
            Ack_in = (j + 1 == ack_off);
            tick();
        end
        Ack_in = 1'b0;
    endtask

    task automatic glitch();
        RXD = 1'b0;
        repeat (4) tick();
        idle(14, 0);
    endtask

    initial begin
        Rst    = 1'b1;
        RXD    = 1'b1;
        Ack_in = 1'b0;
        repeat (3) tick();
        chk("reset_data",  {24'h0, Data_out}, 32'h0);
        chk("reset_valid", {31'h0, Valid_out}, 32'h0);
        Rst = 1'b0;
        idle(20, 0);

        // Clean 0xA5 with exact latency, then acknowledge
        send_frame(8'hA5, 1'b1, 0, 1'b1);
        chk("a5_ovr", {31'h0, Overrun}, 32'h0);
        idle(4, 1);
        chk("a5_acked", {31'h0, Valid_out}, 32'h0);

        // Short low pulse is rejected
        glitch();
        chk("glitch_valid", {31'h0, Valid_out}, 32'h0);
        chk("glitch_data",  {24'h0, Data_out}, 32'hA5);

        // Framing error, then a good frame
        send_frame(8'h3C, 1'b0, 0, 1'b1);
        chk("ferr_data_kept", {24'h0, Data_out}, 32'hA5);
        idle(5, 0);
        send_frame(8'h5A, 1'b1, 0, 1'b1);
        chk("after_ferr_data", {24'h0, Data_out}, 32'h5A);
        idle(4, 1);

        // Overrun: 0x11 then 0x22 without ack
        send_frame(8'h11, 1'b1, 0, 1'b1);
        idle(3, 0);
        send_frame(8'h22, 1'b1, 0, 1'b0);
        chk("ovr_data",  {24'h0, Data_out}, 32'h11);
        chk("ovr_flag",  {31'h0, Overrun}, 32'h1);
        chk("ovr_valid", {31'h0, Valid_out}, 32'h1);
        Ack_in = 1'b1;
        tick();
        Ack_in = 1'b0;
        chk("ovr_ack_valid", {31'h0, Valid_out}, 32'h0);
        chk("ovr_ack_flag",  {31'h0, Overrun}, 32'h0);
        idle(4, 0);

        // Ack coincident with completion loads the new byte
        send_frame(8'h11, 1'b1, 0, 1'b0);
        idle(3, 0);
        send_frame(8'h22, 1'b1, LAT, 1'b0);
        chk("coinc_data",  {24'h0, Data_out}, 32'h22);
        chk("coinc_valid", {31'h0, Valid_out}, 32'h1);
        chk("coinc_ovr",   {31'h0, Overrun}, 32'h0);

        // Reset during data bit 4 of 0xFF while Valid and Overrun are set
        send_frame(8'h33, 1'b1, 0, 1'b0);
        idle(3, 0);
        chk("pre_rst_valid", {31'h0, Valid_out}, 32'h1);
        chk("pre_rst_ovr",   {31'h0, Overrun}, 32'h1);
        begin
            logic [9:0] w;
            w = {1'b1, 8'hFF, 1'b0};
            for (int j = 0; j < 5 * BITC + HALFC; j++) begin
                RXD = w[j / BITC];
                tick();
            end
        end
        Rst = 1'b1;
        #1;
        chk("async_rst_data",  {24'h0, Data_out}, 32'h0);
        chk("async_rst_valid", {31'h0, Valid_out}, 32'h0);
        chk("async_rst_ovr",   {31'h0, Overrun}, 32'h0);
        chk("async_rst_ferr",  {31'h0, Framing_err}, 32'h0);
        tick();
        tick();
        Rst = 1'b0;
        idle(20, 0);
        send_frame(8'h5A, 1'b1, 0, 1'b1);
        idle(4, 1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit         stop;
            int         ack_off;
            b       = 8'($urandom);
            stop    = ($urandom_range(0, 7) != 0);
            ack_off = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 170)) : 0;
            if ($urandom_range(0, 5) == 0) glitch();
            send_frame(b, stop, ack_off, 1'b0);
            idle(int'($urandom_range(2, 12)), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        idle(10, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
